m206: RTL and testbench
=======================

M206 -- requirements
Module: m206

Interface
REQ-001 SHALL: clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: FF0 ports, all 1-bit: A1 in D; B1 in clock pulse C; C1 in direct set, active low; D1 out "1" side; E1 out "0" side.
REQ-004 SHALL: FF1 ports: F1 in D; H1 in C; J1 in set_n; K1 out 1; L1 out 0.
REQ-005 SHALL: FF2 ports: M1 in D; N1 in C; P1 in set_n; R1 out 1; S1 out 0.
REQ-006 SHALL: U1 in 1-bit, direct clear, active low, shared by FF0-FF2.
REQ-007 SHALL: FF3 ports: V1 in D; D2 in C; E2 in set_n; F2 out 1; H2 out 0.
REQ-008 SHALL: FF4 ports: J2 in D; K2 in C; L2 in set_n; M2 out 1; N2 out 0.
REQ-009 SHALL: FF5 ports: P2 in D; R2 in C; S2 in set_n; T2 out 1; U2 out 0.
REQ-010 SHALL: V2 in 1-bit, direct clear, active low, shared by FF3-FF5.
REQ-011 SHALL: power and ground pins A2, B2, C2 and T1 are not ports.

Function
REQ-012 SHALL: every D, C, set_n and clear_n input passes through one register stage (sample) before use.
REQ-013 SHALL: a clock event is sampled C = 1 when the previous sampled C = 0 (rising edge). Level or falling edge: no event.
REQ-014 SHALL: on a clock event, Q <= sampled D from the same cycle as the sampled C = 1.
REQ-015 SHALL: latency is 2 clk edges. An input change before edge k is sampled at k; the output reflects it after edge k+1.
REQ-016 SHALL: sampled set_n = 0 forces Q = 1 at the next edge, overriding a clock event in the same cycle.
REQ-017 SHALL: sampled clear_n = 0 forces Q = 0 at the next edge for all three flip-flops of its group; clear overrides set and clock events.
REQ-018 SHALL: while set_n or clear_n is held low, Q stays forced every cycle and clock events are ignored.
REQ-019 SHALL: the 0-side output is always the exact complement of the 1-side output, including during set/clear conflict.
REQ-020 SHALL: the six flip-flops are independent except for the shared clear per group.
REQ-021 SHALL: all outputs are registered; there is no combinational path from input to output.

Reset
REQ-022 SHALL: reset = 1 sets every Q = 0, so all 1-side outputs = 0 and all 0-side outputs = 1 after the edge.
REQ-023 SHALL: reset loads the sampled-C history = 1, so a C input held high across reset produces no event. A genuine event requires C observed low after reset.
REQ-024 SHALL: reset loads sampled set_n/clear_n = 1 (inactive) and sampled D = 0.
REQ-025 SHALL: reset asserted mid-operation wins over set, clear and clock events in the same cycle.

Structure
REQ-026 SHALL: one sub-module, m206_ff, holds a single flip-flop slice (input samples, edge detect, Q, complement output). m206 instantiates it six times and routes the group clears.
REQ-027 SHALL: no shared package. The flip-flop count (6) and group size (3) are local constants in m206.

Verification
REQ-028 SHALL: after reset with all inputs high → D1 = 0 and E1 = 1 for every flip-flop; no output changes for 10 cycles while C is held high.
REQ-029 SHALL: A1 = 1, then B1 0→1 before edge k → D1 = 1 and E1 = 0 after edge k+1. Then A1 = 0 with B1 held high for 5 cycles → D1 stays 1.
REQ-030 SHALL: J1 = 0 for 1 cycle with H1 idle → K1 = 1 after 2 edges. Then U1 = 0 for 1 cycle → K1, D1 and R1 = 0 after 2 edges; FF3-FF5 unchanged.
REQ-031 SHALL: E2 = 0 and V2 = 0 held together → F2 = 0 and H2 = 1 (clear dominates). Release V2 only → F2 = 1 two edges later.
REQ-032 SHALL: rising edge on R2 with P2 = 1 in the same sampled cycle as S2 = 0 → T2 = 1. Then P2 = 0, S2 = 1, R2 rises → T2 = 0.
REQ-033 SHALL: reset pulsed on the same cycle as a C event and set_n = 0 on FF4 → M2 = 0 and N2 = 1.

Source files
------------

// File: rtl/m206_ff.sv
// m206_ff -- one D flip-flop slice with direct set and direct clear.
//
// Every input is captured in a sample register before it is used. A clock
// event is a sampled C of 1 following a sampled C of 0. Clear dominates set,
// and set dominates a clock event. The 0-side output is the complement of the
// stored bit, so the two sides can never disagree.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high
//   i_d      in   data input
//   i_c      in   clock-pulse input (edge detected on samples)
//   i_set_n  in   direct set, active low
//   i_clr_n  in   direct clear, active low
//   o_q      out  "1" side
//   o_qn     out  "0" side
module m206_ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  input  logic i_c,
  input  logic i_set_n,
  input  logic i_clr_n,
  output logic o_q,
  output logic o_qn
);

  logic r_d_p0;
  logic r_c_p0;
  logic r_set_n_p0;
  logic r_clr_n_p0;
  logic r_c_p1;
  logic r_q_p1;
  logic w_event;

  assign w_event = r_c_p0 & ~r_c_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_p0     <= 1'b0;
      // C history loads high so a C held high through reset is not an edge.
      r_c_p0     <= 1'b1;
      r_c_p1     <= 1'b1;
      r_set_n_p0 <= 1'b1;
      r_clr_n_p0 <= 1'b1;
      r_q_p1     <= 1'b0;
    end else begin
      // Stage p0: input samples
      r_d_p0     <= i_d;
      r_c_p0     <= i_c;
      r_set_n_p0 <= i_set_n;
      r_clr_n_p0 <= i_clr_n;
      // Stage p1: stored bit, plus the previous C sample for edge detection
      r_c_p1     <= r_c_p0;
      if (!r_clr_n_p0)
        r_q_p1 <= 1'b0;
      else if (!r_set_n_p0)
        r_q_p1 <= 1'b1;
      else if (w_event)
        r_q_p1 <= r_d_p0;
    end
  end

  assign o_q  = r_q_p1;
  assign o_qn = ~r_q_p1;

endmodule

// File: rtl/m206.sv
// m206 -- six D flip-flops in two groups of three, each group sharing an
// active-low direct clear.
//
// Ports (all 1-bit):
//   clk, reset                 clock and synchronous active-high reset
//   FF0: A1 D, B1 C, C1 set_n, D1 q, E1 qn
//   FF1: F1 D, H1 C, J1 set_n, K1 q, L1 qn
//   FF2: M1 D, N1 C, P1 set_n, R1 q, S1 qn
//   U1 : clear_n for FF0-FF2
//   FF3: V1 D, D2 C, E2 set_n, F2 q, H2 qn
//   FF4: J2 D, K2 C, L2 set_n, M2 q, N2 qn
//   FF5: P2 D, R2 C, S2 set_n, T2 q, U2 qn
//   V2 : clear_n for FF3-FF5
module m206 (
  input  logic clk,
  input  logic reset,
  input  logic A1,
  input  logic B1,
  input  logic C1,
  output logic D1,
  output logic E1,
  input  logic F1,
  input  logic H1,
  input  logic J1,
  output logic K1,
  output logic L1,
  input  logic M1,
  input  logic N1,
  input  logic P1,
  output logic R1,
  output logic S1,
  input  logic U1,
  input  logic V1,
  input  logic D2,
  input  logic E2,
  output logic F2,
  output logic H2,
  input  logic J2,
  input  logic K2,
  input  logic L2,
  output logic M2,
  output logic N2,
  input  logic P2,
  input  logic R2,
  input  logic S2,
  output logic T2,
  output logic U2,
  input  logic V2
);

  localparam int NUM_FF   = 6;
  localparam int GROUP_SZ = 3;

  logic [NUM_FF-1:0] w_d;
  logic [NUM_FF-1:0] w_c;
  logic [NUM_FF-1:0] w_set_n;
  logic [NUM_FF-1:0] w_clr_n;
  logic [NUM_FF-1:0] w_q;
  logic [NUM_FF-1:0] w_qn;

  assign w_d     = {P2, J2, V1, M1, F1, A1};
  assign w_c     = {R2, K2, D2, N1, H1, B1};
  assign w_set_n = {S2, L2, E2, P1, J1, C1};
  // Lower group (FF0-FF2) clears from U1, upper group (FF3-FF5) from V2.
  assign w_clr_n = {{GROUP_SZ{V2}}, {GROUP_SZ{U1}}};

  for (genvar g = 0; g < NUM_FF; g++) begin : g_ff
    m206_ff u_ff (
      .clk     (clk),
      .reset   (reset),
      .i_d     (w_d[g]),
      .i_c     (w_c[g]),
      .i_set_n (w_set_n[g]),
      .i_clr_n (w_clr_n[g]),
      .o_q     (w_q[g]),
      .o_qn    (w_qn[g])
    );
  end

  assign {T2, M2, F2, R1, K1, D1} = w_q;
  assign {U2, N2, H2, S1, L1, E1} = w_qn;

endmodule

// File: tb/tb_m206.sv
module tb_m206;

  typedef struct packed {
    logic [5:0] d;
    logic [5:0] c;
    logic [5:0] sn;
    logic       u;
    logic       v;
    logic       rst;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] d, c, sn;
  logic u1, v2;
  logic [5:0] q, qn;

  int n_checks = 0;
  int n_err    = 0;

  vec_t       hist [0:2047];
  int         n_edge = 0;
  logic [5:0] qm = '0;
  logic [5:0] saved;

  always #5 clk = ~clk;

  m206 dut (
    .clk(clk), .reset(reset),
    .A1(d[0]), .B1(c[0]), .C1(sn[0]), .D1(q[0]), .E1(qn[0]),
    .F1(d[1]), .H1(c[1]), .J1(sn[1]), .K1(q[1]), .L1(qn[1]),
    .M1(d[2]), .N1(c[2]), .P1(sn[2]), .R1(q[2]), .S1(qn[2]),
    .U1(u1),
    .V1(d[3]), .D2(c[3]), .E2(sn[3]), .F2(q[3]), .H2(qn[3]),
    .J2(d[4]), .K2(c[4]), .L2(sn[4]), .M2(q[4]), .N2(qn[4]),
    .P2(d[5]), .R2(c[5]), .S2(sn[5]), .T2(q[5]), .U2(qn[5]),
    .V2(v2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // What the flip-flops "see" as their sampled inputs after edge k: the
  // values present at that edge, or the inactive defaults if reset was high.
  function automatic vec_t seen(input int k);
    vec_t r;
    r.d = '0; r.c = '1; r.sn = '1; r.u = 1'b1; r.v = 1'b1; r.rst = 1'b0;
    if (k >= 0 && !hist[k].rst) r = hist[k];
    return r;
  endfunction

  // Reference: output after edge n follows from what was seen at edge n-1
  // (and the C seen one edge earlier, for the rising-edge test).
  task automatic model_edge(input int e);
    vec_t s1;
    logic [5:0] cprev;
    logic clr_n;
    s1 = seen(e - 1);
    if (e - 1 < 0) cprev = '1;
    else if (hist[e-1].rst) cprev = '1;
    else cprev = seen(e - 2).c;
    for (int i = 0; i < 6; i++) begin
      clr_n = (i < 3) ? s1.u : s1.v;
      if (hist[e].rst)             qm[i] = 1'b0;
      else if (!clr_n)             qm[i] = 1'b0;
      else if (!s1.sn[i])          qm[i] = 1'b1;
      else if (s1.c[i] && !cprev[i]) qm[i] = s1.d[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    hist[n_edge].d   = d;
    hist[n_edge].c   = c;
    hist[n_edge].sn  = sn;
    hist[n_edge].u   = u1;
    hist[n_edge].v   = v2;
    hist[n_edge].rst = reset;
    model_edge(n_edge);
    n_edge++;
    @(negedge clk);
    chk("model", {20'd0, q, qn}, {20'd0, qm, ~qm});
  endtask

  initial begin
    reset = 1'b1; d = '1; c = '1; sn = '1; u1 = 1'b1; v2 = 1'b1;
    step(); step();
    chk("reset_q", {26'd0, q}, 32'h00);
    chk("reset_qn", {26'd0, qn}, 32'h3f);
    reset = 1'b0;

    // C held high after reset: no event, outputs stay at reset values
    for (int i = 0; i < 10; i++) step();
    chk("hold_high_q", {26'd0, q}, 32'h00);
    chk("hold_high_qn", {26'd0, qn}, 32'h3f);

    // FF0: rising edge of B1 with A1 = 1
    c[0] = 1'b0; step();
    c[0] = 1'b1; step();
    step();
    chk("ff0_load1", {30'd0, q[0], qn[0]}, 32'h2);
    d[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("ff0_level_hold", {31'd0, q[0]}, 32'h1);

    // FF1 set, then group-0 clear
    sn[1] = 1'b0; step();
    sn[1] = 1'b1; step();
    chk("ff1_set", {31'd0, q[1]}, 32'h1);
    saved = q;
    u1 = 1'b0; step();
    u1 = 1'b1; step();
    chk("grp0_clear", {29'd0, q[2:0]}, 32'h0);
    chk("grp1_untouched", {29'd0, q[5:3]}, {29'd0, saved[5:3]});

    // FF3: set and clear together, clear dominates
    sn[3] = 1'b0; v2 = 1'b0;
    step(); step(); step();
    chk("ff3_clr_over_set", {30'd0, q[3], qn[3]}, 32'h1);
    v2 = 1'b1; step(); step();
    chk("ff3_set_after_clr", {31'd0, q[3]}, 32'h1);
    sn[3] = 1'b1;

    // FF5: edge, D = 1 and set in the same sampled cycle
    c[5] = 1'b0; step();
    c[5] = 1'b1; d[5] = 1'b1; sn[5] = 1'b0; step();
    step();
    chk("ff5_set_edge", {31'd0, q[5]}, 32'h1);
    sn[5] = 1'b1; d[5] = 1'b0; c[5] = 1'b0; step();
    c[5] = 1'b1; step();
    step();
    chk("ff5_load0", {31'd0, q[5]}, 32'h0);

    // FF4: reset in the same cycle as an edge and a set
    c[4] = 1'b0; d[4] = 1'b1; step();
    reset = 1'b1; c[4] = 1'b1; sn[4] = 1'b0; step();
    chk("ff4_reset_wins", {30'd0, q[4], qn[4]}, 32'h1);
    reset = 1'b0; sn[4] = 1'b1; step();
    chk("ff4_after_reset", {31'd0, q[4]}, 32'h0);

    // Randomized traffic checked against the reference model
    for (int i = 0; i < 400; i++) begin
      d     = 6'($urandom);
      c     = 6'($urandom);
      sn    = ~(6'($urandom) & 6'($urandom) & 6'($urandom));
      u1    = ($urandom_range(0, 11) != 0);
      v2    = ($urandom_range(0, 11) != 0);
      reset = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
